// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// FSM encodings, enable literals and default bus widths.
package pipe_ctrl_pkg;

   localparam int REG_ADDR_W_DEF = 5;
   localparam int ADDR_W_DEF     = 32;
   localparam int CNT_W_DEF      = 32;

   localparam logic EN  = 1'b1;
   localparam logic DIS = 1'b0;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_DIV_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Core-to-controller bundle: hazard sources from ID/EX/MEM and the
// divider in, stall/flush/redirect/divider controls and counters out.
interface pipe_ctrl_if #(
   parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W_DEF,
   parameter int ADDR_W     = pipe_ctrl_pkg::ADDR_W_DEF,
   parameter int CNT_W      = pipe_ctrl_pkg::CNT_W_DEF
);
   logic [REG_ADDR_W-1:0] id_rs1_addr_i;
   logic                  id_rs1_use_i;
   logic [REG_ADDR_W-1:0] id_rs2_addr_i;
   logic                  id_rs2_use_i;
   logic                  id_div_i;
   logic                  ex_load_i;
   logic [REG_ADDR_W-1:0] ex_rd_addr_i;
   logic                  ex_jump_i;
   logic [ADDR_W-1:0]     ex_jump_addr_i;
   logic                  mem_wait_i;
   logic                  div_done_i;

   logic                  stall_pc_o;
   logic                  stall_if_id_o;
   logic                  stall_id_ex_o;
   logic                  stall_ex_mem_o;
   logic                  flush_if_id_o;
   logic                  flush_id_ex_o;
   logic                  pc_load_o;
   logic [ADDR_W-1:0]     pc_load_addr_o;
   logic                  div_start_o;
   logic                  div_abort_o;
   logic                  div_busy_o;
   logic [CNT_W-1:0]      stall_cnt_o;
   logic [CNT_W-1:0]      flush_cnt_o;

   modport slave (
      input  id_rs1_addr_i, id_rs1_use_i, id_rs2_addr_i, id_rs2_use_i,
             id_div_i, ex_load_i, ex_rd_addr_i, ex_jump_i, ex_jump_addr_i,
             mem_wait_i, div_done_i,
      output stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o,
             flush_if_id_o, flush_id_ex_o, pc_load_o, pc_load_addr_o,
             div_start_o, div_abort_o, div_busy_o, stall_cnt_o, flush_cnt_o
   );

   modport master (
      output id_rs1_addr_i, id_rs1_use_i, id_rs2_addr_i, id_rs2_use_i,
             id_div_i, ex_load_i, ex_rd_addr_i, ex_jump_i, ex_jump_addr_i,
             mem_wait_i, div_done_i,
      input  stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o,
             flush_if_id_o, flush_id_ex_o, pc_load_o, pc_load_addr_o,
             div_start_o, div_abort_o, div_busy_o, stall_cnt_o, flush_cnt_o
   );

endinterface

// File: rtl/pipe_ctrl_hazard.sv
// Load-use comparator: the instruction in ID reads a register that the
// load in EX has not produced yet. x0 never creates a hazard.
module pipe_ctrl_hazard
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  i_ex_load,
   input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr,
   input  logic                  i_rs1_use,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr,
   input  logic                  i_rs2_use,
   output logic                  o_load_use
);

   logic w_rs1_hit;
   logic w_rs2_hit;
   logic w_rd_valid;

   // Source-operand match against the pending load destination
   always_comb begin
      w_rs1_hit  = i_rs1_use & (i_rs1_addr == i_ex_rd_addr);
      w_rs2_hit  = i_rs2_use & (i_rs2_addr == i_ex_rd_addr);
      w_rd_valid = (i_ex_rd_addr != {REG_ADDR_W{1'b0}});
      o_load_use = i_ex_load & w_rd_valid & (w_rs1_hit | w_rs2_hit);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and sequencing controller: prioritised stall/flush and
// PC redirect, divider start/abort scheduling, and stall/flush counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic      clk,
   input  logic      rst,
   pipe_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_load_use;
   logic              w_stall_pc;
   logic              w_stall_if_id;
   logic              w_stall_id_ex;
   logic              w_stall_ex_mem;
   logic              w_flush_if_id;
   logic              w_flush_id_ex;
   logic              w_pc_load;
   logic [ADDR_W-1:0] w_pc_load_addr;
   logic              w_div_start;
   logic              w_div_abort;
   logic              w_div_busy;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   pipe_ctrl_hazard #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard (
      .i_ex_load    (bus.ex_load_i),
      .i_ex_rd_addr (bus.ex_rd_addr_i),
      .i_rs1_addr   (bus.id_rs1_addr_i),
      .i_rs1_use    (bus.id_rs1_use_i),
      .i_rs2_addr   (bus.id_rs2_addr_i),
      .i_rs2_use    (bus.id_rs2_use_i),
      .o_load_use   (w_load_use)
   );

   // Priority mux and next state; reset forces every control low at once
   always_comb begin
      w_state_nxt    = r_state;
      w_stall_pc     = DIS;
      w_stall_if_id  = DIS;
      w_stall_id_ex  = DIS;
      w_stall_ex_mem = DIS;
      w_flush_if_id  = DIS;
      w_flush_id_ex  = DIS;
      w_pc_load      = DIS;
      w_pc_load_addr = {ADDR_W{1'b0}};
      w_div_start    = DIS;
      w_div_abort    = DIS;
      w_div_busy     = DIS;

      if (rst) begin
         w_state_nxt = ST_RUN;
      end else if (bus.mem_wait_i) begin
         // EX is frozen, so a pending jump is re-presented once MEM releases
         w_stall_pc     = EN;
         w_stall_if_id  = EN;
         w_stall_id_ex  = EN;
         w_stall_ex_mem = EN;
      end else if (bus.ex_jump_i) begin
         w_pc_load      = EN;
         w_pc_load_addr = bus.ex_jump_addr_i;
         w_flush_if_id  = EN;
         w_flush_id_ex  = EN;
         w_div_abort    = (r_state == ST_DIV_WAIT);
         w_state_nxt    = ST_RUN;
      end else if (r_state == ST_DIV_WAIT) begin
         if (bus.div_done_i) begin
            w_state_nxt = ST_RUN;
         end else begin
            w_stall_pc    = EN;
            w_stall_if_id = EN;
            w_stall_id_ex = EN;
         end
      end else if (w_load_use) begin
         // One bubble suffices: the load reaches MEM and forwarding covers it
         w_stall_pc    = EN;
         w_stall_if_id = EN;
         w_flush_id_ex = EN;
      end else if (bus.id_div_i) begin
         w_div_start = EN;
         w_state_nxt = ST_DIV_WAIT;
      end else begin
         w_state_nxt = r_state;
      end

      if (!rst && (r_state == ST_DIV_WAIT)) begin
         w_div_busy = EN;
      end else begin
         w_div_busy = DIS;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Performance counters, free-running with natural wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= {CNT_W{1'b0}};
         r_flush_cnt <= {CNT_W{1'b0}};
      end else begin
         if (w_stall_pc) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         end
         if (w_pc_load) begin
            r_flush_cnt <= r_flush_cnt + CNT_ONE;
         end
      end
   end

   assign bus.stall_pc_o     = w_stall_pc;
   assign bus.stall_if_id_o  = w_stall_if_id;
   assign bus.stall_id_ex_o  = w_stall_id_ex;
   assign bus.stall_ex_mem_o = w_stall_ex_mem;
   assign bus.flush_if_id_o  = w_flush_if_id;
   assign bus.flush_id_ex_o  = w_flush_id_ex;
   assign bus.pc_load_o      = w_pc_load;
   assign bus.pc_load_addr_o = w_pc_load_addr;
   assign bus.div_start_o    = w_div_start;
   assign bus.div_abort_o    = w_div_abort;
   assign bus.div_busy_o     = w_div_busy;
   assign bus.stall_cnt_o    = r_stall_cnt;
   assign bus.flush_cnt_o    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model predicts each
// cycle's controls, which are queued at drive time and compared on output.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pipe_ctrl_if pif ();

   pipe_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (pif)
   );

   typedef struct packed {
      logic        stall_pc;
      logic        stall_if_id;
      logic        stall_id_ex;
      logic        stall_ex_mem;
      logic        flush_if_id;
      logic        flush_id_ex;
      logic        pc_load;
      logic [31:0] pc_addr;
      logic        div_start;
      logic        div_abort;
      logic        div_busy;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        m_dw;
   logic [31:0] m_stall_cnt;
   logic [31:0] m_flush_cnt;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   function automatic exp_t observed();
      exp_t o;
      o.stall_pc     = pif.stall_pc_o;
      o.stall_if_id  = pif.stall_if_id_o;
      o.stall_id_ex  = pif.stall_id_ex_o;
      o.stall_ex_mem = pif.stall_ex_mem_o;
      o.flush_if_id  = pif.flush_if_id_o;
      o.flush_id_ex  = pif.flush_id_ex_o;
      o.pc_load      = pif.pc_load_o;
      o.pc_addr      = pif.pc_load_addr_o;
      o.div_start    = pif.div_start_o;
      o.div_abort    = pif.div_abort_o;
      o.div_busy     = pif.div_busy_o;
      return o;
   endfunction

   // Reference behaviour of one cycle given the model state and driven inputs
   task automatic predict(output exp_t e, output logic nxt);
      logic lu;
      e   = '0;
      nxt = m_dw;
      lu  = pif.ex_load_i && (pif.ex_rd_addr_i != 5'd0) &&
            ((pif.id_rs1_use_i && (pif.id_rs1_addr_i == pif.ex_rd_addr_i)) ||
             (pif.id_rs2_use_i && (pif.id_rs2_addr_i == pif.ex_rd_addr_i)));
      e.div_busy = m_dw;
      if (pif.mem_wait_i) begin
         e.stall_pc = 1'b1; e.stall_if_id = 1'b1;
         e.stall_id_ex = 1'b1; e.stall_ex_mem = 1'b1;
      end else if (pif.ex_jump_i) begin
         e.pc_load = 1'b1; e.pc_addr = pif.ex_jump_addr_i;
         e.flush_if_id = 1'b1; e.flush_id_ex = 1'b1;
         e.div_abort = m_dw;
         nxt = 1'b0;
      end else if (m_dw) begin
         if (pif.div_done_i) begin
            nxt = 1'b0;
         end else begin
            e.stall_pc = 1'b1; e.stall_if_id = 1'b1; e.stall_id_ex = 1'b1;
         end
      end else if (lu) begin
         e.stall_pc = 1'b1; e.stall_if_id = 1'b1; e.flush_id_ex = 1'b1;
      end else if (pif.id_div_i) begin
         e.div_start = 1'b1;
         nxt = 1'b1;
      end
   endtask

   task automatic set_idle();
      pif.id_rs1_addr_i  = 5'd0;
      pif.id_rs1_use_i   = 1'b0;
      pif.id_rs2_addr_i  = 5'd0;
      pif.id_rs2_use_i   = 1'b0;
      pif.id_div_i       = 1'b0;
      pif.ex_load_i      = 1'b0;
      pif.ex_rd_addr_i   = 5'd0;
      pif.ex_jump_i      = 1'b0;
      pif.ex_jump_addr_i = 32'd0;
      pif.mem_wait_i     = 1'b0;
      pif.div_done_i     = 1'b0;
   endtask

   // One cycle: predict + enqueue, dequeue + compare, then advance model
   task automatic tick(input string tag);
      exp_t e;
      exp_t got;
      logic nxt;
      #1;
      predict(e, nxt);
      sb_q.push_back(e);
      got = observed();
      e = sb_q.pop_front();
      check_eq(tag, got, e);
      @(posedge clk);
      m_dw = nxt;
      if (e.stall_pc) m_stall_cnt = m_stall_cnt + 32'd1;
      if (e.pc_load)  m_flush_cnt = m_flush_cnt + 32'd1;
      #1;
      check_eq({tag, ".stall_cnt"}, pif.stall_cnt_o, m_stall_cnt);
      check_eq({tag, ".flush_cnt"}, pif.flush_cnt_o, m_flush_cnt);
      @(negedge clk);
   endtask

   initial begin
      set_idle();
      rst = 1'b1;
      m_dw = 1'b0;
      m_stall_cnt = 32'd0;
      m_flush_cnt = 32'd0;
      @(negedge clk);
      check_eq("reset_outputs", observed(), 42'd0);
      check_eq("reset_stall_cnt", pif.stall_cnt_o, 32'd0);
      check_eq("reset_flush_cnt", pif.flush_cnt_o, 32'd0);
      pif.ex_jump_i = 1'b1; pif.ex_jump_addr_i = 32'hDEAD_BEEF; pif.id_div_i = 1'b1;
      #1;
      check_eq("reset_forces_zero", observed(), 42'd0);
      set_idle();
      @(negedge clk);
      rst = 1'b0;
      tick("idle0");

      // Load-use
      pif.ex_load_i = 1'b1; pif.ex_rd_addr_i = 5'd5;
      pif.id_rs1_use_i = 1'b1; pif.id_rs1_addr_i = 5'd5;
      tick("lu_rs1");
      set_idle();
      tick("lu_after");
      check_eq("lu_stall_cnt", pif.stall_cnt_o, 32'd1);
      pif.ex_load_i = 1'b1; pif.ex_rd_addr_i = 5'd0;
      pif.id_rs1_use_i = 1'b1; pif.id_rs1_addr_i = 5'd0;
      tick("lu_rd0");
      pif.ex_rd_addr_i = 5'd7; pif.id_rs1_addr_i = 5'd7; pif.id_rs1_use_i = 1'b0;
      pif.id_rs2_use_i = 1'b1; pif.id_rs2_addr_i = 5'd7;
      tick("lu_rs2");
      pif.id_rs2_use_i = 1'b0;
      tick("lu_nouse");
      set_idle();
      check_eq("lu_stall_cnt2", pif.stall_cnt_o, 32'd2);

      // Divider: 33 waiting cycles, completion drops stalls in the same cycle
      pif.id_div_i = 1'b1;
      tick("div_start");
      pif.id_div_i = 1'b0;
      for (int i = 0; i < 33; i++) tick($sformatf("div_wait%0d", i));
      pif.div_done_i = 1'b1;
      tick("div_done");
      check_eq("div_stall_cnt", pif.stall_cnt_o, 32'd35);
      tick("done_in_run");
      pif.div_done_i = 1'b0;

      // Jump aborts an in-flight divide
      pif.id_div_i = 1'b1;
      tick("div_start2");
      pif.id_div_i = 1'b0;
      tick("dw2a");
      tick("dw2b");
      pif.ex_jump_i = 1'b1; pif.ex_jump_addr_i = 32'h0000_0100;
      tick("jump_abort");
      check_eq("abort_flush_cnt", pif.flush_cnt_o, 32'd1);
      set_idle();
      tick("after_abort");

      // Memory wait masks the jump until it drops
      pif.mem_wait_i = 1'b1; pif.ex_jump_i = 1'b1; pif.ex_jump_addr_i = 32'h0000_2000;
      for (int i = 0; i < 3; i++) tick($sformatf("memwait_jump%0d", i));
      pif.mem_wait_i = 1'b0;
      tick("memwait_release");
      check_eq("memwait_flush_cnt", pif.flush_cnt_o, 32'd2);

      // Jump beats load-use, and suppresses a div start in RUN
      pif.ex_load_i = 1'b1; pif.ex_rd_addr_i = 5'd3;
      pif.id_rs1_use_i = 1'b1; pif.id_rs1_addr_i = 5'd3;
      pif.ex_jump_addr_i = 32'h0000_0044;
      tick("lu_jump");
      set_idle();
      pif.id_div_i = 1'b1; pif.ex_jump_i = 1'b1; pif.ex_jump_addr_i = 32'h0000_0080;
      tick("jump_div_run");
      set_idle();

      // Memory wait during DIV_WAIT keeps the divide pending
      pif.id_div_i = 1'b1;
      tick("div_start3");
      pif.id_div_i = 1'b0; pif.mem_wait_i = 1'b1;
      tick("dw_memwait0");
      tick("dw_memwait1");
      pif.mem_wait_i = 1'b0; pif.div_done_i = 1'b1;
      tick("dw3_done");
      pif.div_done_i = 1'b0;
      tick("dw3_after");

      // Random mix
      for (int i = 0; i < 300; i++) begin
         pif.ex_load_i      = 1'($urandom_range(0, 1));
         pif.ex_rd_addr_i   = 5'($urandom_range(0, 3));
         pif.id_rs1_addr_i  = 5'($urandom_range(0, 3));
         pif.id_rs2_addr_i  = 5'($urandom_range(0, 3));
         pif.id_rs1_use_i   = 1'($urandom_range(0, 1));
         pif.id_rs2_use_i   = 1'($urandom_range(0, 1));
         pif.id_div_i       = ($urandom_range(0, 3) == 0);
         pif.ex_jump_i      = ($urandom_range(0, 7) == 0);
         pif.ex_jump_addr_i = $urandom;
         pif.mem_wait_i     = ($urandom_range(0, 5) == 0);
         pif.div_done_i     = ($urandom_range(0, 7) == 0);
         tick($sformatf("rnd%0d", i));
      end
      set_idle();

      // Asynchronous reset in the middle of a divide
      pif.ex_jump_i = 1'b1; pif.ex_jump_addr_i = 32'h0000_0010;
      tick("pre_rst_jump");
      set_idle();
      pif.id_div_i = 1'b1;
      tick("div_start4");
      pif.id_div_i = 1'b0;
      tick("dw4a");
      tick("dw4b");
      check_eq("dw4_busy", pif.div_busy_o, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      check_eq("midrst_outputs", observed(), 42'd0);
      check_eq("midrst_stall_cnt", pif.stall_cnt_o, 32'd0);
      check_eq("midrst_flush_cnt", pif.flush_cnt_o, 32'd0);
      m_dw = 1'b0;
      m_stall_cnt = 32'd0;
      m_flush_cnt = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      tick("post_rst");
      check_eq("post_rst_busy", pif.div_busy_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
